// File: rtl/ofm_group_accumulator.sv
// ofm_group_accumulator
//   Post-processing stage behind the bit-serial 32-tap convolution core.
//   It sums GROUPS consecutive OFM partial sums into one output pixel and adds
//   a signed bias. It then applies ReLU, rounds half-up, right-shifts by SHIFT
//   and saturates to OUT_W bits. Each result is queued in a small FIFO that
//   the activation writer drains through a valid/ready handshake.
//
// Ports
//   clk_gate_IN1  clock
//   rst_n         asynchronous active-low reset
//   clear         synchronous flush of group count, accumulator, pipe, FIFO, overflow
//   ofm_valid     one-cycle qualifier for ofm_data
//   ofm_data      unsigned partial sum from the core
//   bias          signed bias, sampled on the final-group beat
//   act_valid     FIFO head is readable
//   act_data      FIFO head (0 when empty)
//   act_ready     consumer pops the head when act_valid && act_ready
//   fifo_full     FIFO holds FIFO_DEPTH entries
//   overflow      sticky: a result was dropped because the FIFO was full
//   group_idx     index of the next expected partial sum
module ofm_group_accumulator #(
  parameter int IN_W       = 13,
  parameter int GROUPS     = 4,
  parameter int ACC_W      = 16,
  parameter int OUT_W      = 8,
  parameter int SHIFT      = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int GI_W      = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic             clk_gate_IN1,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             ofm_valid,
  input  logic [IN_W-1:0]  ofm_data,
  input  logic [ACC_W:0]   bias,
  output logic             act_valid,
  output logic [OUT_W-1:0] act_data,
  input  logic             act_ready,
  output logic             fifo_full,
  output logic             overflow,
  output logic [GI_W-1:0]  group_idx
);

  localparam int S_W   = ACC_W + 2;  // signed pre-activation sum
  localparam int R_W   = ACC_W + 3;  // headroom for the rounding add
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PTR_W = AW + 1;     // extra bit distinguishes full from empty

  localparam logic [R_W-1:0]   HALF    = R_W'(1) << (SHIFT - 1);
  localparam logic [R_W-1:0]   OUT_MAX = (R_W'(1) << OUT_W) - R_W'(1);
  localparam logic [GI_W-1:0]  LAST_G  = GI_W'(GROUPS - 1);

  // ---------------------------------------------------------------------------
  // Group accumulation
  // ---------------------------------------------------------------------------
  logic [GI_W-1:0]       grp_q;
  logic [ACC_W-1:0]      acc_q;
  logic                  post_valid_q;
  logic signed [S_W-1:0] post_s_q;
  logic signed [S_W-1:0] bias_ext;
  logic signed [S_W-1:0] sum_s;
  logic                  final_beat;

  assign group_idx  = grp_q;
  assign final_beat = ofm_valid && (grp_q == LAST_G);
  assign bias_ext   = S_W'($signed(bias));

  // NOTE: every variable driven in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    sum_s = '0;
    if (GROUPS == 1) sum_s = $signed(S_W'(ofm_data)) + bias_ext;
    else             sum_s = $signed(S_W'(acc_q) + S_W'(ofm_data)) + bias_ext;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, whatever order the statements appear in.
  always_ff @(posedge clk_gate_IN1 or negedge rst_n) begin
    if (!rst_n) begin
      grp_q        <= '0;
      acc_q        <= '0;
      post_valid_q <= 1'b0;
      post_s_q     <= '0;
    end else if (clear) begin
      grp_q        <= '0;
      acc_q        <= '0;
      post_valid_q <= 1'b0;
      post_s_q     <= '0;
    end else begin
      post_valid_q <= final_beat;  // one-cycle pulse per finished pixel
      if (final_beat) post_s_q <= sum_s;
      if (ofm_valid) begin
        acc_q <= (grp_q == '0) ? ACC_W'(ofm_data) : acc_q + ACC_W'(ofm_data);
        grp_q <= (grp_q == LAST_G) ? '0 : grp_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Requantisation: ReLU, round half up, shift, saturate
  // ---------------------------------------------------------------------------
  logic [R_W-1:0]   rnd;
  logic [R_W-1:0]   shifted;
  logic [OUT_W-1:0] result;

  always_comb begin
    rnd     = R_W'(post_s_q) + HALF;
    shifted = (post_s_q <= 0) ? '0 : (rnd >> SHIFT);
    result  = (shifted > OUT_MAX) ? '1 : shifted[OUT_W-1:0];
  end

  // ---------------------------------------------------------------------------
  // Output FIFO. The read side compares against a one-edge-delayed copy of the
  // write pointer, so a freshly written entry becomes readable on the
  // following edge (no write-to-read bypass).
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_vis_q, rd_ptr_q;
  logic [PTR_W-1:0] occupancy;
  logic             pop, push_ok;

  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign fifo_full = (occupancy == PTR_W'(FIFO_DEPTH));
  assign act_valid = (rd_ptr_q != wr_vis_q);
  assign act_data  = act_valid ? mem[rd_ptr_q[AW-1:0]] : '0;
  assign pop       = act_valid && act_ready;
  // A push into a full FIFO is accepted only when a pop frees a slot this cycle.
  assign push_ok   = post_valid_q && (!fifo_full || pop);

  always_ff @(posedge clk_gate_IN1 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      wr_vis_q <= '0;
      rd_ptr_q <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      wr_vis_q <= '0;
      rd_ptr_q <= '0;
      overflow <= 1'b0;
    end else begin
      wr_vis_q <= wr_ptr_q;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (post_valid_q && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the pointers define which entries
  // are valid, and act_data is forced to 0 while the FIFO is empty.
  always_ff @(posedge clk_gate_IN1) begin
    if (push_ok && !clear) mem[wr_ptr_q[AW-1:0]] <= result;
  end

endmodule

// File: tb/tb_ofm_group_accumulator.sv
// tb_ofm_group_accumulator
//   Directed bench for ofm_group_accumulator with default parameters.
//   Inputs are driven on the falling edge and outputs are checked there too.
//   Expected values are hand-computed from the requantisation formula.
module tb_ofm_group_accumulator;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        ofm_valid;
  logic [12:0] ofm_data;
  logic [16:0] bias;
  logic        act_valid;
  logic [7:0]  act_data;
  logic        act_ready;
  logic        fifo_full;
  logic        overflow;
  logic [1:0]  group_idx;

  int checks = 0;
  int errors = 0;

  ofm_group_accumulator dut (
    .clk_gate_IN1 (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .ofm_valid    (ofm_valid),
    .ofm_data     (ofm_data),
    .bias         (bias),
    .act_valid    (act_valid),
    .act_data     (act_data),
    .act_ready    (act_ready),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .group_idx    (group_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One partial-sum beat; call at a falling edge, returns at the next one.
  task automatic beat(input logic [12:0] d, input logic signed [16:0] b);
    ofm_valid = 1'b1;
    ofm_data  = d;
    bias      = b;
    @(negedge clk);
    ofm_valid = 1'b0;
  endtask

  task automatic send_pixel(input logic [12:0] d0, input logic [12:0] d1,
                            input logic [12:0] d2, input logic [12:0] d3,
                            input logic signed [16:0] b);
    beat(d0, b);
    beat(d1, b);
    beat(d2, b);
    beat(d3, b);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp_data);
    check({tag, "_valid"}, 32'(act_valid), 32'd1);
    check({tag, "_data"},  32'(act_data),  32'(exp_data));
    act_ready = 1'b1;
    @(negedge clk);
    act_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    ofm_valid = 1'b0;
    ofm_data  = '0;
    bias      = '0;
    act_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_act_valid", 32'(act_valid), 32'd0);
    check("rst_act_data",  32'(act_data),  32'd0);
    check("rst_fifo_full", 32'(fifo_full), 32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    check("rst_group_idx", 32'(group_idx), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: 1000 - 40 = 960 -> (960 + 8) >> 4 = 60, visible two edges after beat 4
    beat(13'd100, -17'sd40);
    beat(13'd200, -17'sd40);
    check("t1_group_idx_mid", 32'(group_idx), 32'd2);
    beat(13'd300, -17'sd40);
    beat(13'd400, -17'sd40);
    check("t1_group_idx_wrap", 32'(group_idx), 32'd0);
    check("t1_lat_edge1", 32'(act_valid), 32'd0);
    @(negedge clk);
    check("t1_lat_edge2", 32'(act_valid), 32'd0);
    @(negedge clk);
    pop_check("t1_result", 8'd60);
    check("t1_empty", 32'(act_valid), 32'd0);

    // T2: ReLU and round-half-up boundaries
    send_pixel(13'd0, 13'd0, 13'd0, 13'd10, -17'sd40);  // s = -30 -> 0
    repeat (2) @(negedge clk);
    pop_check("t2_relu", 8'd0);
    send_pixel(13'd0, 13'd0, 13'd0, 13'd24, 17'sd0);     // (24+8)>>4 = 2
    send_pixel(13'd0, 13'd0, 13'd0, 13'd23, 17'sd0);     // (23+8)>>4 = 1
    repeat (2) @(negedge clk);
    pop_check("t2_round24", 8'd2);
    pop_check("t2_round23", 8'd1);

    // T3: 4*8191 = 32764 -> 2048 -> saturates to 255
    send_pixel(13'd8191, 13'd8191, 13'd8191, 13'd8191, 17'sd0);
    repeat (2) @(negedge clk);
    pop_check("t3_saturate", 8'd255);
    check("t3_empty", 32'(act_valid), 32'd0);

    // T4: fill with act_ready low, 5th result dropped, sticky overflow
    repeat (4) send_pixel(13'd100, 13'd200, 13'd300, 13'd400, -17'sd40);
    repeat (2) @(negedge clk);
    check("t4_full_after4", 32'(fifo_full), 32'd1);
    check("t4_no_ovf_yet",  32'(overflow),  32'd0);
    send_pixel(13'd0, 13'd0, 13'd0, 13'd10, 17'sd0);     // would be 1; dropped
    repeat (2) @(negedge clk);
    check("t4_overflow",  32'(overflow),  32'd1);
    check("t4_still_full", 32'(fifo_full), 32'd1);
    check("t4_head_held", 32'(act_data),  32'd60);
    for (int i = 0; i < 4; i++) pop_check("t4_drain", 8'd60);
    check("t4_drained",    32'(act_valid), 32'd0);
    check("t4_not_full",   32'(fifo_full), 32'd0);
    check("t4_ovf_sticky", 32'(overflow),  32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("t4_ovf_cleared", 32'(overflow), 32'd0);

    // T5: push into a full FIFO on the same edge as a pop
    repeat (4) send_pixel(13'd100, 13'd200, 13'd300, 13'd400, -17'sd40);
    repeat (2) @(negedge clk);
    check("t5_full_before", 32'(fifo_full), 32'd1);
    send_pixel(13'd0, 13'd0, 13'd0, 13'd10, 17'sd0);     // (10+8)>>4 = 1
    act_ready = 1'b1;                                     // pop on the push edge
    @(negedge clk);
    act_ready = 1'b0;
    check("t5_occ_full", 32'(fifo_full), 32'd1);
    check("t5_no_ovf",   32'(overflow),  32'd0);
    @(negedge clk);
    pop_check("t5_d0", 8'd60);
    pop_check("t5_d1", 8'd60);
    pop_check("t5_d2", 8'd60);
    pop_check("t5_d3", 8'd1);
    check("t5_empty",     32'(act_valid), 32'd0);
    check("t5_no_ovf_end", 32'(overflow), 32'd0);

    // T6: async reset mid-pixel, then clear together with a beat
    send_pixel(13'd100, 13'd200, 13'd300, 13'd400, -17'sd40);
    repeat (2) @(negedge clk);
    check("t6_pre_valid", 32'(act_valid), 32'd1);
    beat(13'd100, -17'sd40);
    beat(13'd200, -17'sd40);
    check("t6_pre_idx", 32'(group_idx), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_idx",   32'(group_idx), 32'd0);
    check("t6_rst_empty", 32'(act_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_pixel(13'd100, 13'd200, 13'd300, 13'd400, -17'sd40);
    repeat (2) @(negedge clk);
    check("t6_refill", 32'(act_valid), 32'd1);
    beat(13'd100, -17'sd40);
    beat(13'd200, -17'sd40);
    clear = 1'b1;
    beat(13'd300, -17'sd40);
    clear = 1'b0;
    check("t6_clr_idx",   32'(group_idx), 32'd0);
    check("t6_clr_empty", 32'(act_valid), 32'd0);
    check("t6_clr_full",  32'(fifo_full), 32'd0);
    send_pixel(13'd100, 13'd200, 13'd300, 13'd400, -17'sd40);
    repeat (2) @(negedge clk);
    pop_check("t6_clean", 8'd60);
    repeat (3) @(negedge clk);
    check("t6_single", 32'(act_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
